// File: rtl/rib_arbiter_pkg.sv
`timescale 1ns/1ps
// rib_arbiter_pkg: shared types and constants for the RIB arbiter slice.
package rib_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] MASTER_IFETCH = 2'd0;
  localparam logic [1:0] MASTER_LSU    = 2'd1;
  localparam logic [1:0] MASTER_DEBUG  = 2'd2;

  localparam logic HoldEnable  = 1'b1;
  localparam logic HoldDisable = 1'b0;

  // One-hot decode of a master index into the widest legal request vector.
  function automatic logic [3:0] onehot4(input logic [1:0] id);
    onehot4 = 4'b0001 << id;
  endfunction

endpackage

// File: rtl/rib_arbiter_rr_pick.sv
`timescale 1ns/1ps
// rib_rr_pick: combinational round-robin search. Scans (req & mask) starting
// one past last_id, wrapping once; the first set bit wins.
module rib_rr_pick
  import rib_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 3
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [1:0]             last_id,
  output logic [1:0]             winner_id,
  output logic                   found
);

  logic [3:0]  cand;
  int unsigned idx;

  // Walk the candidates in priority order after the last owner.
  always_comb begin
    cand      = 4'(req & mask);
    idx       = 0;
    winner_id = '0;
    found     = 1'b0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      idx = (32'(last_id) + off) % NUM_MASTERS;
      if (!found && cand[2'(idx)]) begin
        winner_id = 2'(idx);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rib_arbiter.sv
`timescale 1ns/1ps
// rib_arbiter: registered round-robin arbiter / transaction sequencer for RIB.
// Optional access timeout with bus error: define RIB_ARB_TIMEOUT_EN.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   slv_ack,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [1:0]             grant_id,
  output logic                   grant_valid,
  output logic [NUM_MASTERS-1:0] done,
  output logic                   bus_err,
  output logic                   hold_flag
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 2 ||
      (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_params
    $error("rib_arbiter: illegal parameter combination");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] done_q, done_d;
  logic [1:0]             grant_id_q, grant_id_d;
  logic [1:0]             last_id_q, last_id_d;
  logic                   grant_valid_q, grant_valid_d;

  logic [NUM_MASTERS-1:0] pick_mask;
  logic [1:0]             pick_last;
  logic [1:0]             pick_id;
  logic                   pick_found;
  logic [3:0]             req_ext;
  logic                   rel_bus;
  logic                   load_new;

`ifdef RIB_ARB_TIMEOUT_EN
  logic [CNT_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic                   bus_err_q, bus_err_d;
`endif

  // Picker inputs: IDLE searches from last_id; BUSY re-arbitrates from the
  // current owner (the pointer it is about to take) and masks it out.
  always_comb begin
    pick_mask = '1;
    pick_last = last_id_q;
    if (state_q == ARB_BUSY) begin
      pick_mask = ~NUM_MASTERS'(onehot4(grant_id_q));
      pick_last = grant_id_q;
    end
  end

  rib_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS)
  ) u_pick (
    .req      (req),
    .mask     (pick_mask),
    .last_id  (pick_last),
    .winner_id(pick_id),
    .found    (pick_found)
  );

  // Next-state: grant on request, release on ack/abandon/timeout, chain grants.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    last_id_d     = last_id_q;
    done_d        = '0;
    rel_bus       = 1'b0;
    load_new      = 1'b0;
    req_ext       = 4'(req);
`ifdef RIB_ARB_TIMEOUT_EN
    wait_cnt_d    = wait_cnt_q;
    bus_err_d     = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        load_new = pick_found;
      end
      ARB_BUSY: begin
        if (slv_ack) begin
          done_d  = NUM_MASTERS'(onehot4(grant_id_q));
          rel_bus = 1'b1;
        end else if (!req_ext[grant_id_q]) begin
          rel_bus = 1'b1;
`ifdef RIB_ARB_TIMEOUT_EN
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          done_d    = NUM_MASTERS'(onehot4(grant_id_q));
          bus_err_d = 1'b1;
          rel_bus   = 1'b1;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
        if (rel_bus) begin
          last_id_d = grant_id_q;
          load_new  = pick_found;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (load_new) begin
      state_d       = ARB_BUSY;
      grant_d       = NUM_MASTERS'(onehot4(pick_id));
      grant_id_d    = pick_id;
      grant_valid_d = 1'b1;
`ifdef RIB_ARB_TIMEOUT_EN
      wait_cnt_d    = '0;
`endif
    end else if (rel_bus) begin
      state_d       = ARB_IDLE;
      grant_d       = '0;
      grant_id_d    = '0;
      grant_valid_d = 1'b0;
    end
  end

  // State and registered outputs; reset kills any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      done_q        <= '0;
      last_id_q     <= 2'(NUM_MASTERS - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      done_q        <= done_d;
      last_id_q     <= last_id_d;
    end
  end

`ifdef RIB_ARB_TIMEOUT_EN
  // Wait counter and bus error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Stall unless only instruction fetch is involved.
  always_comb begin
    hold_flag = HoldDisable;
    if ((|req[NUM_MASTERS-1:1]) ||
        (grant_valid_q && (grant_id_q != MASTER_IFETCH))) begin
      hold_flag = HoldEnable;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign done        = done_q;

endmodule

// File: tb/tb_rib_arbiter.sv
`timescale 1ns/1ps
module tb_rib_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 5;
`ifdef RIB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] req = '0;
  logic         slv_ack = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic         grant_valid;
  logic [N-1:0] done;
  logic         bus_err;
  logic         hold_flag;

  rib_arbiter #(
    .NUM_MASTERS   (N),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .slv_ack    (slv_ack),
    .grant      (grant),
    .grant_id   (grant_id),
    .grant_valid(grant_valid),
    .done       (done),
    .bus_err    (bus_err),
    .hold_flag  (hold_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [1:0]   gid;
    logic         gv;
    logic [N-1:0] done;
    logic         berr;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: owner index (-1 = bus free), last owner, wait cycles.
  int owner = -1;
  int last  = N - 1;
  int wcnt  = 0;

  function automatic int pick(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (from + k) % N;
      if (r[i[1:0]]) return i;
    end
    return -1;
  endfunction

  // One bus cycle: drive inputs, check the stall flag, predict the next edge.
  task automatic step(input logic [N-1:0] r, input logic a);
    obs_t         e;
    logic         exp_hold;
    logic [N-1:0] rm;
    int           w;
    bit           rel;
    @(negedge clk);
    req     = r;
    slv_ack = a;
    #1;
    exp_hold = (r[2:1] != 2'b00) || (owner > 0);
    checks++;
    if (hold_flag !== exp_hold)
      begin
        errors++;
        $display("FAIL hold_flag t=%0t req=%b got=%b exp=%b", $time, r, hold_flag, exp_hold);
      end
    e = '0;
    if (owner < 0) begin
      w = pick(r, last);
      if (w >= 0) begin
        owner = w;
        wcnt  = 0;
      end
    end else begin
      rel = 1'b0;
      if (a) begin
        e.done[owner[1:0]] = 1'b1;
        rel = 1'b1;
      end else if (!r[owner[1:0]]) begin
        rel = 1'b1;
      end else if (TO_EN && wcnt == TO - 1) begin
        e.done[owner[1:0]] = 1'b1;
        e.berr = 1'b1;
        rel = 1'b1;
      end else if (wcnt < (1 << CW) - 1) begin
        wcnt++;
      end
      if (rel) begin
        last = owner;
        rm   = r;
        rm[owner[1:0]] = 1'b0;
        owner = pick(rm, last);
        wcnt  = 0;
      end
    end
    if (owner >= 0) begin
      e.grant[owner[1:0]] = 1'b1;
      e.gid = owner[1:0];
      e.gv  = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Asynchronous reset in the middle of a cycle.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({grant, grant_id, grant_valid, done, bus_err} !== '0)
      begin
        errors++;
        $display("FAIL async_reset got=%b exp=0", {grant, grant_id, grant_valid, done, bus_err});
      end
    owner   = -1;
    last    = N - 1;
    wcnt    = 0;
    req     = '0;
    slv_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compare registered outputs against the oldest prediction.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {grant, grant_id, grant_valid, done, bus_err};
        checks++;
        if (a !== e)
          begin
            errors++;
            $display("FAIL outputs t=%0t got g=%b id=%0d v=%b d=%b e=%b exp g=%b id=%0d v=%b d=%b e=%b",
                     $time, a.grant, a.gid, a.gv, a.done, a.berr,
                     e.grant, e.gid, e.gv, e.done, e.berr);
          end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] r;
    logic         a;
    int           drain;

    // Reset state.
    #12;
    checks++;
    if ({grant, grant_id, grant_valid, done, bus_err, hold_flag} !== '0)
      begin
        errors++;
        $display("FAIL reset_state got=%b exp=0", {grant, grant_id, grant_valid, done, bus_err, hold_flag});
      end
    @(negedge clk);
    rst = 1'b1;

    // Single fetch access, ack two cycles after grant.
    step(3'b001, 1'b0);
    step(3'b001, 1'b0);
    step(3'b001, 1'b0);
    step(3'b001, 1'b1);
    step(3'b000, 1'b0);

    // All masters requesting, ack every busy cycle.
    step(3'b111, 1'b0);
    for (int i = 0; i < 4; i++) step(3'b111, 1'b1);
    step(3'b000, 1'b1);
    step(3'b000, 1'b0);

    // Masters 1 and 2: back-to-back hand-over.
    step(3'b110, 1'b0);
    step(3'b110, 1'b1);
    step(3'b100, 1'b1);
    step(3'b000, 1'b0);

    // Master 2 abandons; master 0 takes over with no done pulse.
    step(3'b100, 1'b0);
    step(3'b100, 1'b0);
    step(3'b001, 1'b0);
    step(3'b001, 1'b1);
    step(3'b000, 1'b0);

    // Long wait with no ack, then ack landing on the terminal cycle.
    step(3'b001, 1'b0);
    for (int i = 0; i < 18; i++) step(3'b001, 1'b0);
    step(3'b001, 1'b1);
    step(3'b000, 1'b0);
    step(3'b001, 1'b0);
    for (int i = 0; i < 15; i++) step(3'b001, 1'b0);
    step(3'b001, 1'b1);
    step(3'b000, 1'b0);

    // Reset while master 1 is busy, then 011 must go to master 0 first.
    step(3'b010, 1'b0);
    step(3'b010, 1'b0);
    mid_reset();
    step(3'b011, 1'b0);
    step(3'b011, 1'b1);
    step(3'b010, 1'b1);
    step(3'b000, 1'b0);

    // Random traffic: sticky requests, frequent then rare acks.
    r = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 7));
      if (i < 300) a = ($urandom_range(0, 3) == 0);
      else         a = ($urandom_range(0, 31) == 0);
      step(r, a);
      if (i == 450) mid_reset();
    end
    step(3'b000, 1'b1);
    step(3'b000, 1'b0);

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Registered round-robin arbiter and transaction sequencer for the RIB bus.
- Decides which master owns the shared slave fabric and holds that grant until the addressed slave acknowledges.
- Issues per-master completion pulses, aborts hung accesses with a bus error, and drives the pipeline hold flag.
- Sits between the master request lines and the RIB address-decode/mux stage, which consumes grant_id.

Parameters:
- NUM_MASTERS, 3, number of requesters; legal range 2..4.
- TIMEOUT_CYCLES, 16, cycles a granted access may wait for slv_ack before a bus error; must be ≥2.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NUM_MASTERS  per-master access request; level, held until done or abandoned.
- slv_ack  in  1  granted slave completes the access this cycle.
- grant  out  NUM_MASTERS  one-hot grant, registered.
- grant_id  out  2  binary index of granted master, registered; drives the RIB mux.
- grant_valid  out  1  a grant is active, registered.
- done  out  NUM_MASTERS  one-cycle completion pulse to the owning master, registered.
- bus_err  out  1  one-cycle pulse when an access is terminated by timeout, registered.
- hold_flag  out  1  pipeline stall request, combinational.

Behaviour:
- Reset (rst=0, asynchronous): grant=0, grant_id=0, grant_valid=0, done=0, bus_err=0, state=IDLE, wait_cnt=0, last_id=NUM_MASTERS-1, so master 0 wins the first arbitration. Deassertion is sampled on clk.
- States: IDLE and BUSY.
- Arbitration function: search req starting at index (last_id+1) mod NUM_MASTERS and wrap once; the first set bit wins.
- IDLE: if any req bit is set, load grant/grant_id for the winner, set grant_valid, clear wait_cnt, go to BUSY. Grant appears 1 cycle after req is first sampled. If no req, stay in IDLE with outputs 0.
- BUSY, slv_ack=1:
  - next cycle, done[grant_id]=1 for 1 cycle and last_id←grant_id;
  - in the same edge, re-arbitrate using the updated pointer, excluding the completing master's req bit;
  - if a winner exists, load the new grant and stay in BUSY (zero-bubble back-to-back); otherwise clear grant and go to IDLE.
- BUSY, req[grant_id]=0 without ack (master abandons): release as for ack but with no done pulse; last_id←grant_id; re-arbitrate.
- BUSY otherwise: wait_cnt increments, saturating at 2^CNT_W-1.
- done and bus_err are never asserted for more than one cycle per access.
- A completing master that still holds req is re-granted only after all other requesters get a turn.
- grant stays one-hot or zero at all times; grant_valid == |grant.
- hold_flag = (|req[NUM_MASTERS-1:1]) | (grant_valid & grant_id≠0). Master 0 (instruction fetch) alone never stalls the pipeline.
- Reset asserted mid-access: all outputs go to their reset values immediately; no done or bus_err is emitted for the killed access.

Optional Feature:
- Macro: RIB_ARB_TIMEOUT_EN.
- Defined: in BUSY, when wait_cnt reaches TIMEOUT_CYCLES-1 and slv_ack=0, the next cycle shows bus_err=1 and done[grant_id]=1 for one cycle, and the grant is released and re-arbitrated as on ack. If ack and the timeout terminal count coincide, ack wins and bus_err stays 0.
- Undefined: no timeout; wait_cnt logic is removed; bus_err is tied 0; a grant lasts until ack or abandon.

Decomposition:
- Shared package/defines: state encodings (ARB_IDLE, ARB_BUSY), master index constants (MASTER_IFETCH=0, MASTER_LSU=1, MASTER_DEBUG=2), and the reuse of HoldEnable/HoldDisable from the global defines.
- One sub-module: rib_rr_pick. Purely combinational; takes req, a mask and last_id; returns winner index and a found flag. It is used both for the IDLE pick and for back-to-back re-arbitration.

Test Plan:
- Reset, then req=3'b001 with slv_ack raised 2 cycles after grant → grant=001 one cycle after req, done=001 one cycle after ack, hold_flag=0 throughout.
- req=3'b111 held, slv_ack=1 every BUSY cycle → grant order 001, 010, 100, 001 with no idle cycles; one done pulse per grant.
- req=3'b110, ack to master 1 → master 2 granted on the same edge as master 1's done; hold_flag=1 throughout.
- Master 2 granted, req[2] dropped with no ack → no done pulse; master 0 (req=001) granted the next cycle.
- RIB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, slv_ack never asserted → bus_err=1 and done=grant exactly 16 cycles after grant; ack on cycle 16 instead → bus_err=0.
- rst pulled low while BUSY with master 1 → grant=0 and done=0 asynchronously; after release, req=3'b011 grants master 0 first.
